// File: rtl/m_rf_sb.sv
// m_rf_sb: multi-port register file with per-register busy scoreboard and sticky halt.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
`default_nettype none

module m_rf_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int HALT_REG = 30
) (
  input  logic                    w_clock,
  input  logic                    w_reset,
  input  logic [NREAD*ADDR_W-1:0] w_ra,
  output logic [NREAD*DATA_W-1:0] w_rd,
  output logic [NREAD-1:0]        w_rv,
  input  logic                    w_we0,
  input  logic                    w_we1,
  input  logic [ADDR_W-1:0]       w_wa0,
  input  logic [ADDR_W-1:0]       w_wa1,
  input  logic [DATA_W-1:0]       w_wd0,
  input  logic [DATA_W-1:0]       w_wd1,
  input  logic                    w_bset,
  input  logic [ADDR_W-1:0]       w_ba,
  output logic [ADDR_W:0]         w_busy_cnt,
  output logic                    w_halt
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [CNT_W-1:0]  busy_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              halt;

  logic wr0_ok, wr1_ok, bset_ok, halt_hit;
  logic inc, dec0, dec1;

  assign wr0_ok   = w_we0 && (w_wa0 != '0) && !halt;
  assign wr1_ok   = w_we1 && (w_wa1 != '0) && !halt;
  assign bset_ok  = w_bset && (w_ba != '0) && !halt;
  assign halt_hit = !halt && ((w_we0 && (w_wa0 == HALT_ADDR)) ||
                              (w_we1 && (w_wa1 == HALT_ADDR)));

  // Busy-set is applied last so a newly issued producer overrides a retiring write.
  always_comb begin
    busy_next = busy;
    if (wr0_ok)  busy_next[w_wa0] = 1'b0;
    if (wr1_ok)  busy_next[w_wa1] = 1'b0;
    if (bset_ok) busy_next[w_ba]  = 1'b1;
  end

  // Counter tracks only the bits that actually flip, each counted once.
  always_comb begin
    inc  = bset_ok && !busy[w_ba];
    dec0 = wr0_ok && busy[w_wa0] && !(bset_ok && (w_ba == w_wa0));
    dec1 = wr1_ok && busy[w_wa1] && !(bset_ok && (w_ba == w_wa1)) &&
           !(wr0_ok && (w_wa0 == w_wa1));
    cnt_next = busy_cnt + CNT_W'(inc) - CNT_W'(dec0) - CNT_W'(dec1);
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      halt     <= 1'b0;
    end else if (!halt) begin
      if (wr0_ok) mem[w_wa0] <= w_wd0;
      if (wr1_ok) mem[w_wa1] <= w_wd1;
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      if (halt_hit) halt <= 1'b1;
    end
  end

  assign w_busy_cnt = busy_cnt;
  assign w_halt     = halt;

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rv;

    assign ra = w_ra[k*ADDR_W +: ADDR_W];

`ifdef RF_BYPASS_EN
    always_comb begin
      rd = mem[ra];
      rv = !busy[ra];
      if (!w_reset && wr1_ok && (w_wa1 == ra)) begin
        rd = w_wd1;
        rv = 1'b1;
      end else if (!w_reset && wr0_ok && (w_wa0 == ra)) begin
        rd = w_wd0;
        rv = 1'b1;
      end
    end
`else
    always_comb begin
      rd = mem[ra];
      rv = !busy[ra];
    end
`endif

    assign w_rd[k*DATA_W +: DATA_W] = rd;
    assign w_rv[k]                  = rv;
  end

endmodule

`default_nettype wire

// File: tb/tb_m_rf_sb.sv
// Self-checking bench for m_rf_sb: directed scenarios plus randomized traffic against a reference model.
`default_nettype none

module tb_m_rf_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;
  localparam int DEPTH  = 32;

  logic                    clk = 1'b0;
  logic                    w_reset;
  logic [NREAD*ADDR_W-1:0] w_ra;
  logic [NREAD*DATA_W-1:0] w_rd;
  logic [NREAD-1:0]        w_rv;
  logic                    w_we0, w_we1;
  logic [ADDR_W-1:0]       w_wa0, w_wa1;
  logic [DATA_W-1:0]       w_wd0, w_wd1;
  logic                    w_bset;
  logic [ADDR_W-1:0]       w_ba;
  logic [ADDR_W:0]         w_busy_cnt;
  logic                    w_halt;

  logic [DATA_W-1:0] rd0, rd1;
  assign rd0 = w_rd[31:0];
  assign rd1 = w_rd[63:32];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_busy [DEPTH];
  bit                m_halt;

  always #5 clk = ~clk;

  m_rf_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .HALT_REG(30)) dut (
    .w_clock(clk), .w_reset(w_reset), .w_ra(w_ra), .w_rd(w_rd), .w_rv(w_rv),
    .w_we0(w_we0), .w_we1(w_we1), .w_wa0(w_wa0), .w_wa1(w_wa1),
    .w_wd0(w_wd0), .w_wd1(w_wd1), .w_bset(w_bset), .w_ba(w_ba),
    .w_busy_cnt(w_busy_cnt), .w_halt(w_halt)
  );

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_halt = 1'b0;
  endtask

  // Architectural effect of one clock edge given the inputs present at that edge.
  task automatic model_edge();
    bit hit;
    if (!m_halt) begin
      hit = (w_we0 && w_wa0 == 5'd30) || (w_we1 && w_wa1 == 5'd30);
      if (w_we0 && w_wa0 != 0) begin m_mem[w_wa0] = w_wd0; m_busy[w_wa0] = 1'b0; end
      if (w_we1 && w_wa1 != 0) begin m_mem[w_wa1] = w_wd1; m_busy[w_wa1] = 1'b0; end
      if (w_bset && w_ba != 0) m_busy[w_ba] = 1'b1;
      if (hit) m_halt = 1'b1;
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
`ifdef RF_BYPASS_EN
    if (!w_reset && !m_halt && a != 0 && w_we1 && w_wa1 == a) return w_wd1;
    if (!w_reset && !m_halt && a != 0 && w_we0 && w_wa0 == a) return w_wd0;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_rv(input logic [ADDR_W-1:0] a);
`ifdef RF_BYPASS_EN
    if (!w_reset && !m_halt && a != 0 && ((w_we1 && w_wa1 == a) || (w_we0 && w_wa0 == a))) return 1'b1;
`endif
    return !m_busy[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    w_we0 = 1'b0; w_we1 = 1'b0; w_bset = 1'b0;
  endtask

  task automatic pulse_reset();
    w_reset = 1'b1;
    model_reset();
    @(negedge clk);
    w_reset = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, 31));
    return a;
  endfunction

  task automatic test_reset();
    n_tests++; if (w_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_init_cnt: got %0d expected 0", w_busy_cnt); end
    n_tests++; if (w_halt !== 1'b0) begin n_fail++; $display("FAIL reset_init_halt: got %b expected 0", w_halt); end
    w_we0 = 1'b1; w_wa0 = 5'd5; w_wd0 = 32'h55;
    w_bset = 1'b1; w_ba = 5'd9;
    tick();
    w_ra = {5'd9, 5'd5};
    #1;
    n_tests++; if (rd0 !== 32'h55) begin n_fail++; $display("FAIL reset_pre_rd: got %h expected %h", rd0, 32'h55); end
    n_tests++; if (w_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL reset_pre_cnt: got %0d expected 1", w_busy_cnt); end
    #1;
    w_reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_async_rd: got %h/%h expected 0/0", rd0, rd1); end
    n_tests++; if (w_rv !== 2'b11) begin n_fail++; $display("FAIL reset_async_rv: got %b expected 11", w_rv); end
    n_tests++; if (w_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_async_cnt: got %0d expected 0", w_busy_cnt); end
    n_tests++; if (w_halt !== 1'b0) begin n_fail++; $display("FAIL reset_async_halt: got %b expected 0", w_halt); end
    @(negedge clk);
    w_reset = 1'b0;
  endtask

  task automatic test_collision();
    w_we0 = 1'b1; w_wa0 = 5'd5; w_wd0 = 32'h11;
    w_we1 = 1'b1; w_wa1 = 5'd5; w_wd1 = 32'h22;
    tick();
    w_we0 = 1'b1; w_wa0 = 5'd0; w_wd0 = 32'hFF;
    w_ra = {5'd0, 5'd5};
    #1;
    n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL r0_write_same_cycle: got %h expected 0", rd1); end
    tick();
    #1;
    n_tests++; if (rd0 !== 32'h22) begin n_fail++; $display("FAIL collision_rd: got %h expected %h", rd0, 32'h22); end
    n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL r0_read: got %h expected 0", rd1); end
    n_tests++; if (w_rv[1] !== 1'b1) begin n_fail++; $display("FAIL r0_rv: got %b expected 1", w_rv[1]); end
  endtask

  task automatic test_scoreboard();
    w_bset = 1'b1; w_ba = 5'd7;
    tick();
    w_ra = {5'd0, 5'd7};
    #1;
    n_tests++; if (w_rv[0] !== 1'b0) begin n_fail++; $display("FAIL sb_set_rv: got %b expected 0", w_rv[0]); end
    n_tests++; if (w_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_set_cnt: got %0d expected 1", w_busy_cnt); end
    w_we0 = 1'b1; w_wa0 = 5'd7; w_wd0 = 32'hAB;
    tick();
    #1;
    n_tests++; if (w_rv[0] !== 1'b1) begin n_fail++; $display("FAIL sb_clr_rv: got %b expected 1", w_rv[0]); end
    n_tests++; if (rd0 !== 32'hAB) begin n_fail++; $display("FAIL sb_clr_rd: got %h expected %h", rd0, 32'hAB); end
    n_tests++; if (w_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL sb_clr_cnt: got %0d expected 0", w_busy_cnt); end
    w_bset = 1'b1; w_ba = 5'd7;
    w_we1 = 1'b1; w_wa1 = 5'd7; w_wd1 = 32'hCD;
    tick();
    #1;
    n_tests++; if (w_rv[0] !== 1'b0) begin n_fail++; $display("FAIL sb_setwins_rv: got %b expected 0", w_rv[0]); end
    n_tests++; if (rd0 !== 32'hCD) begin n_fail++; $display("FAIL sb_setwins_rd: got %h expected %h", rd0, 32'hCD); end
    n_tests++; if (w_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_setwins_cnt: got %0d expected 1", w_busy_cnt); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] e;
    w_we0 = 1'b1; w_wa0 = 5'd3; w_wd0 = 32'h5555;
    tick();
    w_we0 = 1'b1; w_wa0 = 5'd3; w_wd0 = 32'h1234;
    w_ra = {5'd0, 5'd3};
    #1;
`ifdef RF_BYPASS_EN
    e = 32'h1234;
`else
    e = 32'h5555;
`endif
    n_tests++; if (rd0 !== e) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rd0, e); end
    n_tests++; if (w_rv[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_rv: got %b expected 1", w_rv[0]); end
    tick();
    #1;
    n_tests++; if (rd0 !== 32'h1234) begin n_fail++; $display("FAIL bypass_next_cycle: got %h expected %h", rd0, 32'h1234); end
    w_we0 = 1'b1; w_wa0 = 5'd3; w_wd0 = 32'hAAAA;
    w_we1 = 1'b1; w_wa1 = 5'd3; w_wd1 = 32'hBBBB;
    #1;
`ifdef RF_BYPASS_EN
    e = 32'hBBBB;
`else
    e = 32'h1234;
`endif
    n_tests++; if (rd0 !== e) begin n_fail++; $display("FAIL bypass_port1_prio: got %h expected %h", rd0, e); end
    tick();
    #1;
    n_tests++; if (rd0 !== 32'hBBBB) begin n_fail++; $display("FAIL collision_port1_after: got %h expected %h", rd0, 32'hBBBB); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int n = 0; n < 300; n++) begin
      w_we0  = 1'($urandom_range(0, 1));
      w_we1  = 1'($urandom_range(0, 1));
      w_bset = 1'($urandom_range(0, 1));
      a = rand_addr(); w_wa0 = (a == 5'd30) ? 5'd31 : a;
      a = rand_addr(); w_wa1 = (a == 5'd30) ? 5'd31 : a;
      w_ba  = rand_addr();
      w_wd0 = $urandom;
      w_wd1 = $urandom;
      for (int k = 0; k < NREAD; k++) w_ra[k*ADDR_W +: ADDR_W] = rand_addr();
      #1;
      for (int k = 0; k < NREAD; k++) begin
        a = w_ra[k*ADDR_W +: ADDR_W];
        n_tests++;
        if (w_rd[k*DATA_W +: DATA_W] !== exp_rd(a)) begin
          n_fail++; $display("FAIL rand_rd[%0d] r%0d cyc %0d: got %h expected %h", k, a, n, w_rd[k*DATA_W +: DATA_W], exp_rd(a));
        end
        n_tests++;
        if (w_rv[k] !== exp_rv(a)) begin
          n_fail++; $display("FAIL rand_rv[%0d] r%0d cyc %0d: got %b expected %b", k, a, n, w_rv[k], exp_rv(a));
        end
      end
      tick();
      n_tests++;
      if (int'(w_busy_cnt) != model_cnt()) begin
        n_fail++; $display("FAIL rand_cnt cyc %0d: got %0d expected %0d", n, w_busy_cnt, model_cnt());
      end
      n_tests++;
      if (w_halt !== m_halt) begin
        n_fail++; $display("FAIL rand_halt cyc %0d: got %b expected %b", n, w_halt, m_halt);
      end
    end
  endtask

  task automatic test_halt();
    pulse_reset();
    w_we0 = 1'b1; w_wa0 = 5'd30; w_wd0 = 32'h1;
    w_we1 = 1'b1; w_wa1 = 5'd6;  w_wd1 = 32'h66;
    w_bset = 1'b1; w_ba = 5'd8;
    tick();
    w_ra = {5'd6, 5'd30};
    #1;
    n_tests++; if (w_halt !== 1'b1) begin n_fail++; $display("FAIL halt_rise: got %b expected 1", w_halt); end
    n_tests++; if (rd0 !== 32'h1) begin n_fail++; $display("FAIL halt_r30: got %h expected 1", rd0); end
    n_tests++; if (rd1 !== 32'h66) begin n_fail++; $display("FAIL halt_same_cycle_wr: got %h expected %h", rd1, 32'h66); end
    n_tests++; if (w_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL halt_cnt: got %0d expected 1", w_busy_cnt); end
    w_we0 = 1'b1; w_wa0 = 5'd4;  w_wd0 = 32'h9;
    w_we1 = 1'b1; w_wa1 = 5'd30; w_wd1 = 32'h77;
    w_bset = 1'b1; w_ba = 5'd4;
    w_ra = {5'd30, 5'd4};
    #1;
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL halt_no_bypass: got %h expected 0", rd0); end
    tick();
    #1;
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL halt_frozen_rd: got %h expected 0", rd0); end
    n_tests++; if (w_rv[0] !== 1'b1) begin n_fail++; $display("FAIL halt_frozen_rv: got %b expected 1", w_rv[0]); end
    n_tests++; if (rd1 !== 32'h1) begin n_fail++; $display("FAIL halt_frozen_r30: got %h expected 1", rd1); end
    n_tests++; if (w_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL halt_frozen_cnt: got %0d expected 1", w_busy_cnt); end
    n_tests++; if (w_halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b expected 1", w_halt); end
    w_reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (w_halt !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got %b expected 0", w_halt); end
    n_tests++; if (w_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL halt_reset_cnt: got %0d expected 0", w_busy_cnt); end
    @(negedge clk);
    w_reset = 1'b0;
  endtask

  initial begin
    w_reset = 1'b1;
    w_ra = '0;
    w_we0 = 1'b0; w_we1 = 1'b0; w_wa0 = '0; w_wa1 = '0;
    w_wd0 = '0; w_wd1 = '0; w_bset = 1'b0; w_ba = '0;
    model_reset();
    #12;
    w_reset = 1'b0;
    test_reset();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
